systolic_skew_feeder: RTL and testbench

//  Edge driver for the PE systolic array: the transmitting side of the PE u/l operand streams.

---
 rtl/systolic_pkg.sv | 10 +
 rtl/skew_delay.sv | 29 ++
 rtl/systolic_skew_feeder.sv | 78 +++++++
 tb/tb_systolic_skew_feeder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM encoding and default array dimensions for edge feeders and PE array
package systolic_pkg;
    localparam int SYS_N = 3;
    localparam int SYS_W = 8;
    localparam int SYS_K = 3;
    localparam logic [1:0] FILL   = 2'd0;
    localparam logic [1:0] CLEAR  = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
endpackage

// File: rtl/skew_delay.sv
// skew_delay: D-stage zero-reset shift register; D=0 degenerates to a wire
module skew_delay #(
    parameter int W = 8,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    generate
        if (D == 0) begin : g_wire
            logic unused;
            assign unused = ^{clk, rst};
            assign q = d;
        end else begin : g_sr
            logic [W-1:0] sr [D];
            // shift one stage per cycle; reset flushes every stage to zero
            always_ff @(posedge clk) begin
                if (!rst) sr <= '{default: '0};
                else begin
                    sr[0] <= d;
                    for (int j = 1; j < D; j++) sr[j] <= sr[j-1];
                end
            end
            assign q = sr[D-1];
        end
    endgenerate
endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: buffers K vectors, then streams them diagonally skewed into a PE array edge
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N = SYS_N,
    parameter int W = SYS_W,
    parameter int K = SYS_K
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    output logic           pe_clear,
    output logic           out_valid,
    output logic [N*W-1:0] out_data,
    output logic           done
);
    localparam int CW = $clog2(K + 1);
    localparam int TW = $clog2(K + N);
    logic [1:0]     st;
    logic [CW-1:0]  cnt;
    logic [TW-1:0]  t;
    logic [N*W-1:0] vbuf [K];
    logic [N*W-1:0] feed;
    logic [N*W-1:0] skewed;
    // job sequencing: fill K vectors, one clear cycle, K+N-1 stream cycles, one done cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            st  <= FILL;
            cnt <= '0;
            t   <= '0;
        end else begin
            case (st)
                FILL: if (in_valid) begin
                    cnt <= (cnt == CW'(K - 1)) ? '0 : cnt + CW'(1);
                    st  <= (cnt == CW'(K - 1)) ? CLEAR : FILL;
                end
                CLEAR: begin
                    st <= STREAM;
                    t  <= '0;
                end
                STREAM: begin
                    t  <= t + TW'(1);
                    st <= (t == TW'(K + N - 2)) ? DONE : STREAM;
                end
                default: st <= FILL;
            endcase
        end
    end
    // capture accepted vectors into the job buffer slot selected by the fill count
    always_ff @(posedge clk) begin
        if (rst && st == FILL && in_valid)
            for (int k = 0; k < K; k++)
                if (cnt == CW'(k)) vbuf[k] <= in_data;
    end
    // unskewed source: vector t during the first K stream cycles, zero padding otherwise
    always_comb begin
        feed = '0;
        for (int k = 0; k < K; k++)
            if (st == STREAM && t == TW'(k)) feed = vbuf[k];
    end
    generate
        for (genvar i = 0; i < N; i++) begin : g_lane
            skew_delay #(.W(W), .D(i)) u_dly (
                .clk(clk),
                .rst(rst),
                .d  (feed[i*W +: W]),
                .q  (skewed[i*W +: W])
            );
        end
    endgenerate
    assign in_ready  = st == FILL;
    assign pe_clear  = st == CLEAR;
    assign out_valid = st == STREAM;
    assign done      = st == DONE;
    assign out_data  = out_valid ? skewed : '0;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: random and directed checks of the skew feeder against a schedule model
module tb_systolic_skew_feeder;
    localparam int N = 3;
    localparam int W = 8;
    localparam int K = 3;
    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic           in_ready, pe_clear, out_valid, done;
    logic [N*W-1:0] out_data;
    logic           pv = 1'b0;
    logic [7:0]     pu = '0, pl = '0;
    logic           ur, uc, uv, udn, lr, lc, lv, ldn;
    logic [7:0]     uo, lo;
    logic [7:0]     acc = '0;
    logic [7:0]     accs [4];
    int             ai = 0;
    int             vecs = 0, errs = 0;
    int             mcnt = 0, mpos = -1;
    logic [N*W-1:0] job [K];
    logic [N*W-1:0] cap [K+N-1];
    bit             armed = 0, lit_on = 0;
    always #5 clk = ~clk;
    systolic_skew_feeder #(.N(N), .W(W), .K(K)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pe_clear(pe_clear), .out_valid(out_valid), .out_data(out_data), .done(done)
    );
    systolic_skew_feeder #(.N(1), .W(8), .K(3)) feed_u (
        .clk(clk), .rst(rst), .in_valid(pv), .in_ready(ur), .in_data(pu),
        .pe_clear(uc), .out_valid(uv), .out_data(uo), .done(udn)
    );
    systolic_skew_feeder #(.N(1), .W(8), .K(3)) feed_l (
        .clk(clk), .rst(rst), .in_valid(pv), .in_ready(lr), .in_data(pl),
        .pe_clear(lc), .out_valid(lv), .out_data(lo), .done(ldn)
    );
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask
    task automatic timeout(input string nm);
        vecs++;
        errs++;
        $display("FAIL %s: wait bound expired", nm);
    endtask
    function automatic logic [23:0] p3(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction
    // mpos: -1 while filling, 0 clear, 1..K+N-1 stream (t = mpos-1), K+N done
    function automatic logic [N*W-1:0] exp_data();
        logic [N*W-1:0] e = '0;
        if (mpos >= 1 && mpos <= K + N - 1)
            for (int i = 0; i < N; i++)
                if (mpos - 1 - i >= 0 && mpos - 1 - i < K)
                    e[i*W +: W] = job[mpos-1-i][i*W +: W];
        return e;
    endfunction
    // behavioural job schedule
    always @(posedge clk) begin
        if (!rst) begin
            mcnt  <= 0;
            mpos  <= -1;
            armed <= 1;
        end else if (mpos < 0) begin
            if (in_valid) begin
                job[mcnt] <= in_data;
                mcnt <= (mcnt == K - 1) ? 0 : mcnt + 1;
                if (mcnt == K - 1) mpos <= 0;
            end
        end else begin
            mpos <= (mpos == K + N) ? -1 : mpos + 1;
        end
    end
    // compare every cycle on the falling edge
    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready", in_ready, mpos < 0);
            chk("pe_clear", pe_clear, mpos == 0);
            chk("out_valid", out_valid, mpos >= 1 && mpos <= K + N - 1);
            chk("done", done, mpos == K + N);
            chk("out_data", out_data, exp_data());
            if (lit_on && mpos >= 1 && mpos <= K + N - 1) cap[mpos-1] <= out_data;
        end
    end
    // 1x1 PE fed by the two single-lane feeders
    always @(posedge clk) begin
        if (uc) acc <= '0;
        else if (uv) begin
            acc <= 8'(acc + uo * lo);
            if (ai < 4) accs[ai] <= 8'(acc + uo * lo);
            ai <= ai + 1;
        end
    end
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask
    task automatic send(input logic [N*W-1:0] v);
        int n = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (mpos >= 0 && n < 200) begin
            cyc();
            n++;
        end
        if (n >= 200) timeout("send");
        cyc();
        in_valid = 1'b0;
    endtask
    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cyc();
    endtask
    task automatic wait_idle();
        int n = 0;
        while (mpos >= 0 && n < 50) begin
            cyc();
            n++;
        end
        if (n >= 50) timeout("wait_idle");
    endtask
    task automatic wait_pos(input int p);
        int n = 0;
        while (mpos != p && n < 200) begin
            cyc();
            n++;
        end
        if (n >= 200) timeout("wait_pos");
    endtask
    task automatic check_basic(input string nm);
        chk({nm, "_t0"}, cap[0], 24'h000001);
        chk({nm, "_t1"}, cap[1], 24'h000204);
        chk({nm, "_t2"}, cap[2], 24'h030507);
        chk({nm, "_t3"}, cap[3], 24'h060800);
        chk({nm, "_t4"}, cap[4], 24'h090000);
    endtask
    initial begin
        logic [7:0] ut [3];
        logic [7:0] lt [3];
        ut = '{8'd7, 8'd3, 8'd12};
        lt = '{8'd5, 8'd2, 8'd7};
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_clear", pe_clear, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        #1 rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            pv = 1'b1;
            pu = ut[j];
            pl = lt[j];
            cyc();
        end
        pv = 1'b0;
        repeat (8) cyc();
        chk("pe_cnt", ai, 3);
        chk("pe_acc0", accs[0], 35);
        chk("pe_acc1", accs[1], 41);
        chk("pe_acc2", accs[2], 125);
        lit_on = 1;
        send(p3(1, 2, 3));
        send(p3(4, 5, 6));
        send(p3(7, 8, 9));
        wait_idle();
        check_basic("basic");
        send(p3(1, 2, 3));
        idle(2);
        send(p3(4, 5, 6));
        idle(1);
        send(p3(7, 8, 9));
        wait_idle();
        check_basic("gappy");
        lit_on = 0;
        send(24'($urandom));
        send(24'($urandom));
        send(24'($urandom));
        wait_pos(2);
        send(p3(12, 7, 3));
        lit_on = 1;
        send(24'($urandom));
        send(24'($urandom));
        wait_idle();
        lit_on = 0;
        chk("bp_l0", cap[0][7:0], 12);
        chk("bp_l1", cap[1][15:8], 7);
        chk("bp_l2", cap[2][23:16], 3);
        send(24'($urandom));
        send(24'($urandom));
        send(24'($urandom));
        wait_pos(3);
        rst = 1'b0;
        cyc();
        chk("abort_valid", out_valid, 0);
        chk("abort_data", out_data, 0);
        rst = 1'b1;
        lit_on = 1;
        send(p3(1, 2, 3));
        send(p3(4, 5, 6));
        send(p3(7, 8, 9));
        wait_idle();
        check_basic("restart");
        lit_on = 0;
        for (int r = 0; r < 30; r++) begin
            for (int v = 0; v < K; v++) begin
                idle($urandom_range(0, 2));
                send(24'($urandom));
            end
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
